// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected core: default widths and
// the layer sequencer state encoding.
package fc_pkg;

  localparam int FC_ADDR_W   = 64;
  localparam int FC_HEIGHT_W = 9;
  localparam int FC_NEURON_W = 10;
  localparam int FC_RES_W    = 32;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_RD,
    WB,
    FINISH
  } fc_sched_state_e;

endpackage

// File: rtl/fc_layer_sched_if.sv
// Bundle of the layer sequencer's control, read-master, MAC and write-back
// signals. The master modport is the sequencer's view; the slave modport is
// the view of the surrounding CSR block, read master, MAC and write-back path.
interface fc_layer_sched_if
  import fc_pkg::*;
#(
  parameter int ADDR_W   = FC_ADDR_W,
  parameter int HEIGHT_W = FC_HEIGHT_W,
  parameter int NEURON_W = FC_NEURON_W,
  parameter int RES_W    = FC_RES_W
);

  logic                cfg_start_i;
  logic                cfg_abort_i;
  logic [ADDR_W-1:0]   cfg_base_i;
  logic [HEIGHT_W-1:0] cfg_height_i;
  logic [NEURON_W-1:0] cfg_neurons_i;
  logic                busy_o;
  logic                done_o;
  logic                rm_start_o;
  logic [ADDR_W-1:0]   rm_addr_o;
  logic [HEIGHT_W-1:0] rm_height_o;
  logic                rm_done_i;
  logic                mac_clr_o;
  logic                mac_valid_i;
  logic [RES_W-1:0]    mac_result_i;
  logic                wb_valid_o;
  logic                wb_ready_i;
  logic [NEURON_W-1:0] wb_index_o;
  logic [RES_W-1:0]    wb_data_o;

  modport master (
    input  cfg_start_i, cfg_abort_i, cfg_base_i, cfg_height_i, cfg_neurons_i,
    input  rm_done_i, mac_valid_i, mac_result_i, wb_ready_i,
    output busy_o, done_o, rm_start_o, rm_addr_o, rm_height_o, mac_clr_o,
    output wb_valid_o, wb_index_o, wb_data_o
  );

  modport slave (
    output cfg_start_i, cfg_abort_i, cfg_base_i, cfg_height_i, cfg_neurons_i,
    output rm_done_i, mac_valid_i, mac_result_i, wb_ready_i,
    input  busy_o, done_o, rm_start_o, rm_addr_o, rm_height_o, mac_clr_o,
    input  wb_valid_o, wb_index_o, wb_data_o
  );

endinterface

// File: rtl/fc_row_addr_gen.sv
// Row-address accumulator: loads the layer base, steps by one row
// (height+1 words) per neuron and wraps silently at 2^ADDR_W.
module fc_row_addr_gen
  import fc_pkg::*;
#(
  parameter int ADDR_W   = FC_ADDR_W,
  parameter int HEIGHT_W = FC_HEIGHT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_load,
  input  logic                i_inc,
  input  logic [ADDR_W-1:0]   i_base,
  input  logic [HEIGHT_W-1:0] i_height,
  output logic [ADDR_W-1:0]   o_addr
);

  logic [HEIGHT_W:0] w_step;
  logic [ADDR_W-1:0] w_stepExt;
  logic [ADDR_W-1:0] r_addr;

  // One extra bit so a full-range height plus one cannot overflow the step.
  assign w_step    = {1'b0, i_height} + {{HEIGHT_W{1'b0}}, 1'b1};
  assign w_stepExt = ADDR_W'(w_step);
  assign o_addr    = r_addr;

  // Clear wins over load, load wins over increment.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
    end else if (i_inc) begin
      r_addr <= r_addr + w_stepExt;
    end
  end

endmodule

// File: rtl/fc_layer_sched.sv
// Layer sequencer: for each output neuron launch one read burst with an
// accumulator clear, wait for both read completion and the MAC result,
// then hand the result to write-back before moving on to the next row.
module fc_layer_sched
  import fc_pkg::*;
#(
  parameter int ADDR_W   = FC_ADDR_W,
  parameter int HEIGHT_W = FC_HEIGHT_W,
  parameter int NEURON_W = FC_NEURON_W,
  parameter int RES_W    = FC_RES_W
) (
  input logic              clk,
  input logic              rst,
  fc_layer_sched_if.master bus
);

  fc_sched_state_e     r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_rmStart;
  logic                r_macClr;
  logic                r_wbValid;
  logic                r_rdSeen;
  logic                r_macSeen;
  logic [HEIGHT_W-1:0] r_height;
  logic [NEURON_W-1:0] r_neurons;
  logic [NEURON_W-1:0] r_idx;
  logic [RES_W-1:0]    r_result;

  logic                w_start;
  logic                w_abort;
  logic                w_handshake;
  logic                w_lastIdx;
  logic                w_rdSeen;
  logic                w_macSeen;
  logic [ADDR_W-1:0]   w_rmAddr;

  assign w_start     = bus.cfg_start_i && (r_state == IDLE);
  assign w_abort     = bus.cfg_abort_i && (r_state != IDLE);
  assign w_handshake = (r_state == WB) && r_wbValid && bus.wb_ready_i;
  assign w_lastIdx   = (r_idx == (r_neurons - NEURON_W'(1)));
  assign w_rdSeen    = r_rdSeen || bus.rm_done_i;
  assign w_macSeen   = r_macSeen || bus.mac_valid_i;

  fc_row_addr_gen #(
    .ADDR_W   (ADDR_W),
    .HEIGHT_W (HEIGHT_W)
  ) u_rowAddr (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_abort),
    .i_load   (w_start),
    .i_inc    (w_handshake && !w_lastIdx && !w_abort),
    .i_base   (bus.cfg_base_i),
    .i_height (r_height),
    .o_addr   (w_rmAddr)
  );

  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.rm_start_o  = r_rmStart;
  assign bus.rm_addr_o   = w_rmAddr;
  assign bus.rm_height_o = r_height;
  assign bus.mac_clr_o   = r_macClr;
  assign bus.wb_valid_o  = r_wbValid;
  assign bus.wb_index_o  = r_idx;
  assign bus.wb_data_o   = r_result;

  // Sequencer FSM with registered outputs; abort beats every other event.
  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rmStart <= 1'b0;
      r_macClr  <= 1'b0;
      r_wbValid <= 1'b0;
      r_rdSeen  <= 1'b0;
      r_macSeen <= 1'b0;
      r_height  <= '0;
      r_neurons <= '0;
      r_idx     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_height  <= bus.cfg_height_i;
            r_neurons <= bus.cfg_neurons_i;
            r_idx     <= '0;
            r_rdSeen  <= 1'b0;
            r_macSeen <= 1'b0;
            r_busy    <= 1'b1;
            if (bus.cfg_neurons_i != '0) begin
              r_state   <= LAUNCH;
              r_rmStart <= 1'b1;
              r_macClr  <= 1'b1;
            end else begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          r_rmStart <= 1'b0;
          r_macClr  <= 1'b0;
          r_state   <= WAIT_RD;
        end
        WAIT_RD: begin
          if (bus.mac_valid_i) begin
            r_result <= bus.mac_result_i;
          end
          if (w_rdSeen && w_macSeen) begin
            r_rdSeen  <= 1'b0;
            r_macSeen <= 1'b0;
            r_wbValid <= 1'b1;
            r_state   <= WB;
          end else begin
            r_rdSeen  <= w_rdSeen;
            r_macSeen <= w_macSeen;
          end
        end
        WB: begin
          if (w_handshake) begin
            r_wbValid <= 1'b0;
            if (w_lastIdx) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_idx     <= r_idx + NEURON_W'(1);
              r_state   <= LAUNCH;
              r_rmStart <= 1'b1;
              r_macClr  <= 1'b1;
            end
          end
        end
        FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sched.sv
// Directed self-checking bench for the layer sequencer: basic layer, event
// ordering, write-back back-pressure, empty layer, ignored restart, abort,
// reset mid-layer and address wrap.
module tb_fc_layer_sched;

  logic clk;
  logic rst;
  int   testsRun;
  int   failCount;
  bit   injectStart;
  logic [8:0] expHeight;

  fc_layer_sched_if bus ();

  fc_layer_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle; everything after this sits 1 unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse cfg_start for one cycle with the given layer configuration.
  task automatic applyStimulus(input logic [63:0] base, input logic [8:0] height,
                               input logic [9:0] neurons);
    bus.cfg_base_i    = base;
    bus.cfg_height_i  = height;
    bus.cfg_neurons_i = neurons;
    bus.cfg_start_i   = 1'b1;
    tick();
    bus.cfg_start_i   = 1'b0;
    expHeight         = height;
  endtask

  // Every output must read zero and no done pulse may appear.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},   64'(bus.busy_o), 64'd0);
    checkOutput({tag, "_done"},   64'(bus.done_o), 64'd0);
    checkOutput({tag, "_rmst"},   64'(bus.rm_start_o), 64'd0);
    checkOutput({tag, "_addr"},   bus.rm_addr_o, 64'd0);
    checkOutput({tag, "_hgt"},    64'(bus.rm_height_o), 64'd0);
    checkOutput({tag, "_clr"},    64'(bus.mac_clr_o), 64'd0);
    checkOutput({tag, "_wbv"},    64'(bus.wb_valid_o), 64'd0);
    checkOutput({tag, "_wbi"},    64'(bus.wb_index_o), 64'd0);
    checkOutput({tag, "_wbd"},    64'(bus.wb_data_o), 64'd0);
  endtask

  // Serve one neuron, starting in its LAUNCH cycle. mode: 0 = MAC result
  // first, 1 = read done first, 2 = both in the same cycle.
  task automatic serveNeuron(input int mode, input logic [31:0] res,
                             input logic [63:0] expAddr, input logic [9:0] expIdx,
                             input int wbDelay, input bit last,
                             input logic [63:0] nextAddr);
    checkOutput("launch_rmst", 64'(bus.rm_start_o), 64'd1);
    checkOutput("launch_clr",  64'(bus.mac_clr_o), 64'd1);
    checkOutput("launch_addr", bus.rm_addr_o, expAddr);
    if (injectStart) begin
      bus.cfg_base_i    = 64'h9000;
      bus.cfg_height_i  = 9'd7;
      bus.cfg_neurons_i = 10'd0;
      bus.cfg_start_i   = 1'b1;
    end
    tick();
    bus.cfg_start_i = 1'b0;
    injectStart     = 1'b0;
    checkOutput("wait_rmst", 64'(bus.rm_start_o), 64'd0);
    checkOutput("wait_busy", 64'(bus.busy_o), 64'd1);
    bus.mac_result_i = res;
    if (mode == 2) begin
      bus.mac_valid_i = 1'b1;
      bus.rm_done_i   = 1'b1;
      tick();
    end else begin
      if (mode == 0) bus.mac_valid_i = 1'b1;
      else           bus.rm_done_i   = 1'b1;
      tick();
      bus.mac_valid_i  = 1'b0;
      bus.rm_done_i    = 1'b0;
      bus.mac_result_i = 32'hDEAD_BEEF;
      checkOutput("early_wbv", 64'(bus.wb_valid_o), 64'd0);
      if (mode == 0) bus.rm_done_i   = 1'b1;
      else begin
        bus.mac_result_i = res;
        bus.mac_valid_i  = 1'b1;
      end
      tick();
    end
    bus.mac_valid_i = 1'b0;
    bus.rm_done_i   = 1'b0;
    checkOutput("wb_valid",  64'(bus.wb_valid_o), 64'd1);
    checkOutput("wb_index",  64'(bus.wb_index_o), 64'(expIdx));
    checkOutput("wb_data",   64'(bus.wb_data_o), 64'(res));
    checkOutput("wb_height", 64'(bus.rm_height_o), 64'(expHeight));
    for (int d = 0; d < wbDelay; d++) begin
      if (d == 0) begin
        bus.mac_result_i = 32'h5555_AAAA;
        bus.mac_valid_i  = 1'b1;
        bus.rm_done_i    = 1'b1;
      end
      tick();
      bus.mac_valid_i = 1'b0;
      bus.rm_done_i   = 1'b0;
      checkOutput("bp_valid", 64'(bus.wb_valid_o), 64'd1);
      checkOutput("bp_index", 64'(bus.wb_index_o), 64'(expIdx));
      checkOutput("bp_data",  64'(bus.wb_data_o), 64'(res));
      checkOutput("bp_rmst",  64'(bus.rm_start_o), 64'd0);
    end
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
    checkOutput("post_wbv", 64'(bus.wb_valid_o), 64'd0);
    if (last) begin
      checkOutput("last_done", 64'(bus.done_o), 64'd1);
      checkOutput("last_rmst", 64'(bus.rm_start_o), 64'd0);
      tick();
      checkOutput("idle_done", 64'(bus.done_o), 64'd0);
      checkOutput("idle_busy", 64'(bus.busy_o), 64'd0);
    end else begin
      checkOutput("next_done", 64'(bus.done_o), 64'd0);
      checkOutput("next_addr", bus.rm_addr_o, nextAddr);
    end
  endtask

  // Directed test sequence.
  initial begin
    testsRun         = 0;
    failCount        = 0;
    injectStart      = 1'b0;
    expHeight        = '0;
    rst              = 1'b1;
    bus.cfg_start_i  = 1'b0;
    bus.cfg_abort_i  = 1'b0;
    bus.cfg_base_i   = '0;
    bus.cfg_height_i = '0;
    bus.cfg_neurons_i = '0;
    bus.rm_done_i    = 1'b0;
    bus.mac_valid_i  = 1'b0;
    bus.mac_result_i = '0;
    bus.wb_ready_i   = 1'b0;
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    $display("[TB] basic layer with all event orders");
    applyStimulus(64'h1000, 9'd3, 10'd3);
    checkOutput("start_busy", 64'(bus.busy_o), 64'd1);
    serveNeuron(2, 32'hA000_0001, 64'h1000, 10'd0, 0, 1'b0, 64'h1004);
    serveNeuron(0, 32'hA000_0002, 64'h1004, 10'd1, 0, 1'b0, 64'h1008);
    serveNeuron(1, 32'hA000_0003, 64'h1008, 10'd2, 0, 1'b1, 64'h0);

    $display("[TB] back-pressure, restart ignored, cfg changes ignored");
    applyStimulus(64'h2000, 9'd3, 10'd2);
    injectStart = 1'b1;
    serveNeuron(0, 32'h1234_5678, 64'h2000, 10'd0, 5, 1'b0, 64'h2004);
    serveNeuron(2, 32'h8765_4321, 64'h2004, 10'd1, 2, 1'b1, 64'h0);

    $display("[TB] empty layer");
    applyStimulus(64'h4000, 9'd5, 10'd0);
    checkOutput("empty_done", 64'(bus.done_o), 64'd1);
    checkOutput("empty_rmst", 64'(bus.rm_start_o), 64'd0);
    tick();
    checkOutput("empty_done2", 64'(bus.done_o), 64'd0);
    checkOutput("empty_rmst2", 64'(bus.rm_start_o), 64'd0);
    checkOutput("empty_busy2", 64'(bus.busy_o), 64'd0);

    $display("[TB] abort in WAIT_RD");
    applyStimulus(64'h5000, 9'd2, 10'd2);
    tick();
    bus.cfg_abort_i  = 1'b1;
    bus.mac_valid_i  = 1'b1;
    bus.rm_done_i    = 1'b1;
    bus.mac_result_i = 32'h0BAD_0BAD;
    tick();
    bus.cfg_abort_i = 1'b0;
    bus.mac_valid_i = 1'b0;
    bus.rm_done_i   = 1'b0;
    checkAllZero("abort");
    tick();
    checkOutput("abort_done2", 64'(bus.done_o), 64'd0);
    checkOutput("abort_wbv2",  64'(bus.wb_valid_o), 64'd0);
    applyStimulus(64'h6000, 9'd0, 10'd1);
    serveNeuron(2, 32'hCAFE_0001, 64'h6000, 10'd0, 0, 1'b1, 64'h0);

    $display("[TB] reset in WB");
    applyStimulus(64'h3000, 9'd2, 10'd2);
    tick();
    bus.mac_valid_i  = 1'b1;
    bus.rm_done_i    = 1'b1;
    bus.mac_result_i = 32'h7777_7777;
    tick();
    bus.mac_valid_i = 1'b0;
    bus.rm_done_i   = 1'b0;
    checkOutput("rstwb_wbv", 64'(bus.wb_valid_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkAllZero("rstwb");
    tick();
    checkOutput("rstwb_done2", 64'(bus.done_o), 64'd0);
    applyStimulus(64'h7000, 9'd4, 10'd2);
    serveNeuron(1, 32'h0000_0011, 64'h7000, 10'd0, 0, 1'b0, 64'h7005);
    serveNeuron(0, 32'h0000_0022, 64'h7005, 10'd1, 0, 1'b1, 64'h0);

    $display("[TB] address wrap");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFE, 9'd1, 10'd2);
    serveNeuron(2, 32'hFFFF_0000, 64'hFFFF_FFFF_FFFF_FFFE, 10'd0, 0, 1'b0, 64'h0);
    serveNeuron(2, 32'h0000_FFFF, 64'h0, 10'd1, 0, 1'b1, 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
